// File: rtl/serial_src_pkg.sv
// -----------------------------------------------------------------------------
// serial_src_pkg
// Shared definitions for the serial bit source:
//   state_t  - shifter FSM state encoding
//   GAP_W    - width of the inter-word idle-gap counter
//   next_bit - selects the bit currently presented at the serial output end
// -----------------------------------------------------------------------------
package serial_src_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  localparam int GAP_W = 4;

  // shift_reg is passed zero-extended to 32 bits so one function serves every
  // WIDTH; width tells it where the MSB of the real word sits.
  function automatic logic next_bit(input logic [31:0] shift_reg,
                                    input int          width,
                                    input bit          msb_first);
    if (msb_first) return shift_reg[5'(width - 1)];
    return shift_reg[0];
  endfunction

endpackage

// File: rtl/serial_bit_source_if.sv
// -----------------------------------------------------------------------------
// serial_bit_source_if
// Parallel word handshake into the serial bit source.
//   in_data  - word to serialize
//   in_valid - in_data is valid
//   in_ready - source can take a word; transfer on in_valid && in_ready at clk
// Modports: master = word producer, slave = serial_bit_source.
// -----------------------------------------------------------------------------
interface serial_bit_source_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/serial_src_hold.sv
// -----------------------------------------------------------------------------
// serial_src_hold
// One-word holding register between the parallel handshake and the shifter.
//   clk, reset - clock, asynchronous active-high reset
//   in_data    - word offered by the producer
//   in_valid   - producer handshake valid
//   in_ready   - register empty and not in reset
//   take       - shifter consumes the held word at this edge
//   hold_full  - a word is held
//   hold_data  - the held word
// The data register is not reset; only hold_full qualifies it.
// -----------------------------------------------------------------------------
module serial_src_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);

  logic accept;

  // Ready drops combinationally with reset so nothing is accepted while the
  // block is held in reset.
  assign in_ready = !hold_full && !reset;
  assign accept   = in_valid && in_ready;

  // accept and take are mutually exclusive: take needs hold_full, accept needs
  // !hold_full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= in_data;
    end
  end

endmodule

// File: rtl/serial_bit_source.sv
// -----------------------------------------------------------------------------
// serial_bit_source
// Serializes parallel words into a qualified one-bit stream for the Moore
// sequence detectors.
// Parameters:
//   WIDTH     - bits per word (2..32)
//   MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  - dout value whenever dout_valid is low
//   GAP       - idle cycles inserted after every word (0..15)
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   in_if      - word handshake (slave side)
//   dout       - serial bit (drives detector din)
//   dout_valid - dout carries a data bit
//   sof        - first bit of a word
//   busy       - shifting, in a gap, or a word is held
// All serial outputs decode from registers only.
// -----------------------------------------------------------------------------
module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int GAP       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  serial_bit_source_if.slave         in_if,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       sof,
  output logic                       busy
);

  localparam int                CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               take;
  logic               hold_full;
  logic [WIDTH-1:0]   hold_data;
  logic               hold_ready;

  serial_src_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_if.in_data),
    .in_valid  (in_if.in_valid),
    .in_ready  (hold_ready),
    .take      (take),
    .hold_full (hold_full),
    .hold_data (hold_data)
  );

  assign in_if.in_ready = hold_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    take      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full) begin
          take      = 1'b1;
          shift_d   = hold_data;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          // The counter is reloaded explicitly so it never relies on
          // power-of-two wrap.
          bit_cnt_d = '0;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_RELOAD;
          end else if (hold_full) begin
            // Back-to-back reload keeps dout_valid high with no bubble.
            take    = 1'b1;
            shift_d = hold_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else if (hold_full) begin
          take      = 1'b1;
          shift_d   = hold_data;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Shift data is qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign dout_valid = (state_q == S_SHIFT);
  assign dout       = dout_valid ? next_bit(32'(shift_q), WIDTH, MSB_FIRST) : IDLE_BIT;
  assign sof        = dout_valid && (bit_cnt_q == '0);
  assign busy       = (state_q != S_IDLE) || hold_full;

endmodule

// File: tb/tb_serial_bit_source.sv
module tb_serial_bit_source;

  localparam int W    = 8;
  localparam int MAXW = 128;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  // dut0: MSB first, GAP 0, idle 0
  // dut1: MSB first, GAP 2, idle 1
  // dut2: LSB first, GAP 0, idle 0
  serial_bit_source_if #(.WIDTH(W)) if0 ();
  serial_bit_source_if #(.WIDTH(W)) if1 ();
  serial_bit_source_if #(.WIDTH(W)) if2 ();

  logic [W-1:0] drv_data [3];
  logic         drv_valid[3];
  logic         o_dout[3], o_dv[3], o_sof[3], o_busy[3], o_rdy[3];

  assign if0.in_data  = drv_data[0];
  assign if0.in_valid = drv_valid[0];
  assign if1.in_data  = drv_data[1];
  assign if1.in_valid = drv_valid[1];
  assign if2.in_data  = drv_data[2];
  assign if2.in_valid = drv_valid[2];
  assign o_rdy[0] = if0.in_ready;
  assign o_rdy[1] = if1.in_ready;
  assign o_rdy[2] = if2.in_ready;

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .in_if(if0),
    .dout(o_dout[0]), .dout_valid(o_dv[0]), .sof(o_sof[0]), .busy(o_busy[0]));
  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP(2)) dut1 (
    .clk(clk), .reset(reset), .in_if(if1),
    .dout(o_dout[1]), .dout_valid(o_dv[1]), .sof(o_sof[1]), .busy(o_busy[1]));
  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP(0)) dut2 (
    .clk(clk), .reset(reset), .in_if(if2),
    .dout(o_dout[2]), .dout_valid(o_dv[2]), .sof(o_sof[2]), .busy(o_busy[2]));

  function automatic int cfg_gap(input int d);
    return (d == 1) ? 2 : 0;
  endfunction
  function automatic bit cfg_msb(input int d);
    return (d != 2);
  endfunction
  function automatic bit cfg_idle(input int d);
    return (d == 1);
  endfunction

  // Reference model: each accepted word i has an accept edge a and a start
  // cycle s. s = max(a+1, s_prev + W + GAP). The word occupies cycles
  // [s, s+W) on the wire and the block is busy until s+W+GAP.
  int           nw[3];
  int           wa[3][MAXW];
  int           ws[3][MAXW];
  logic [W-1:0] wdat[3][MAXW];
  logic [W-1:0] offer[3][MAXW];
  int           off_rd[3], off_wr[3];
  logic         pend[3];
  int           valid_pct;
  int           t;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int          col_d, col_n, col_max;
  logic [31:0] col_bits, col_dv, col_sof;

  // returns {dout_valid, dout, sof, busy, in_ready}
  function automatic logic [4:0] model_out(input int d, input int tc);
    logic v, b, s, bz, r;
    logic [W-1:0] w;
    int k;
    v = 1'b0; b = cfg_idle(d); s = 1'b0; bz = 1'b0; r = 1'b1;
    for (int i = 0; i < nw[d]; i++) begin
      if (tc >= ws[d][i] && tc < ws[d][i] + W) begin
        w = wdat[d][i];
        k = tc - ws[d][i];
        v = 1'b1;
        b = cfg_msb(d) ? w[3'(W - 1 - k)] : w[3'(k)];
        s = (k == 0);
      end
      if (tc >= wa[d][i] && tc < ws[d][i]) r = 1'b0;
      if (tc >= wa[d][i] && tc < ws[d][i] + W + cfg_gap(d)) bz = 1'b1;
    end
    return {v, b, s, bz, r};
  endfunction

  task automatic push_word(input int d, input logic [W-1:0] w);
    offer[d][off_wr[d]] = w;
    off_wr[d]++;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      nw[d] = 0; off_rd[d] = 0; off_wr[d] = 0; pend[d] = 1'b0;
      drv_valid[d] = 1'b0; drv_data[d] = '0;
    end
    t = 0;
  endtask

  task automatic advance();
    for (int d = 0; d < 3; d++) begin
      logic [4:0] e;
      int s;
      if (!pend[d]) begin
        drv_valid[d] = 1'b0;
        drv_data[d]  = W'($urandom);
        if (off_rd[d] < off_wr[d] && int'($urandom_range(99)) < valid_pct) begin
          drv_data[d]  = offer[d][off_rd[d]];
          drv_valid[d] = 1'b1;
          off_rd[d]++;
          pend[d] = 1'b1;
        end
      end
      e = model_out(d, t);
      if (pend[d] && e[0]) begin
        s = t + 2;
        if (nw[d] > 0 && ws[d][nw[d]-1] + W + cfg_gap(d) > s)
          s = ws[d][nw[d]-1] + W + cfg_gap(d);
        wa[d][nw[d]]   = t + 1;
        ws[d][nw[d]]   = s;
        wdat[d][nw[d]] = drv_data[d];
        nw[d]++;
        pend[d] = 1'b0;
      end
    end
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic col_start(input int d, input int n);
    col_d = d; col_max = n; col_n = 0;
    col_bits = '0; col_dv = '0; col_sof = '0;
  endtask

  task automatic collect();
    if (col_n < col_max && (col_n > 0 || o_dv[col_d])) begin
      col_bits = {col_bits[30:0], o_dout[col_d]};
      col_dv   = {col_dv[30:0],   o_dv[col_d]};
      col_sof  = {col_sof[30:0],  o_sof[col_d]};
      col_n++;
    end
  endtask

  task automatic test_reset();
    logic [4:0] got_v, exp_v;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
      exp_v = {1'b0, cfg_idle(d), 1'b0, 1'b0, 1'b0};
      chk_cnt++;
      if (got_v !== exp_v) $display("FAIL reset_hold dut%0d got %b expected %b", d, got_v, exp_v);
      else pass_cnt++;
    end
    clear_model();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_cnt++;
      if (o_rdy[d] !== 1'b1) $display("FAIL reset_release_ready dut%0d got %b expected 1", d, o_rdy[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [4:0] got_v, exp_v;
    valid_pct = 100;
    push_word(0, 8'h99);
    col_start(0, 10);
    repeat (16) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL single dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      collect();
      advance();
    end
    chk_cnt++;
    if (col_bits[9:0] !== 10'b1001100100) $display("FAIL single_bits got %b expected %b", col_bits[9:0], 10'b1001100100);
    else pass_cnt++;
    chk_cnt++;
    if (col_dv[9:0] !== 10'b1111111100) $display("FAIL single_valid got %b expected %b", col_dv[9:0], 10'b1111111100);
    else pass_cnt++;
    chk_cnt++;
    if (col_sof[9:0] !== 10'b1000000000) $display("FAIL single_sof got %b expected %b", col_sof[9:0], 10'b1000000000);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] got_v, exp_v;
    valid_pct = 100;
    push_word(0, 8'h90);
    push_word(0, 8'h09);
    col_start(0, 16);
    repeat (24) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      collect();
      advance();
    end
    chk_cnt++;
    if (col_bits[15:0] !== 16'b1001000000001001) $display("FAIL b2b_bits got %b expected %b", col_bits[15:0], 16'b1001000000001001);
    else pass_cnt++;
    chk_cnt++;
    if (col_dv[15:0] !== 16'hFFFF) $display("FAIL b2b_valid got %b expected %b", col_dv[15:0], 16'hFFFF);
    else pass_cnt++;
    chk_cnt++;
    if (col_sof[15:0] !== 16'b1000000010000000) $display("FAIL b2b_sof got %b expected %b", col_sof[15:0], 16'b1000000010000000);
    else pass_cnt++;
  endtask

  task automatic test_gap();
    logic [4:0] got_v, exp_v;
    valid_pct = 100;
    push_word(1, 8'hFF);
    push_word(1, 8'h00);
    col_start(1, 18);
    repeat (26) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL gap dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      collect();
      advance();
    end
    chk_cnt++;
    if (col_dv[17:0] !== 18'b111111110011111111) $display("FAIL gap_valid got %b expected %b", col_dv[17:0], 18'b111111110011111111);
    else pass_cnt++;
    chk_cnt++;
    if (col_bits[17:0] !== 18'b111111111100000000) $display("FAIL gap_bits got %b expected %b", col_bits[17:0], 18'b111111111100000000);
    else pass_cnt++;
  endtask

  task automatic test_lsb_first();
    logic [4:0] got_v, exp_v;
    valid_pct = 100;
    push_word(2, 8'h01);
    col_start(2, 8);
    repeat (14) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL lsb dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      collect();
      advance();
    end
    chk_cnt++;
    if (col_bits[7:0] !== 8'b10000000) $display("FAIL lsb_bits got %b expected %b", col_bits[7:0], 8'b10000000);
    else pass_cnt++;
    chk_cnt++;
    if (col_sof[7:0] !== 8'b10000000) $display("FAIL lsb_sof got %b expected %b", col_sof[7:0], 8'b10000000);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [4:0]  got_v, exp_v;
    logic [23:0] abc;
    valid_pct = 100;
    abc = 24'($urandom);
    push_word(0, abc[23:16]);
    push_word(0, abc[15:8]);
    push_word(0, abc[7:0]);
    col_start(0, 24);
    repeat (32) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL backpressure dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      collect();
      advance();
    end
    chk_cnt++;
    if (col_bits[23:0] !== abc) $display("FAIL backpressure_stream got %h expected %h", col_bits[23:0], abc);
    else pass_cnt++;
    chk_cnt++;
    if (col_dv[23:0] !== 24'hFFFFFF) $display("FAIL backpressure_valid got %h expected %h", col_dv[23:0], 24'hFFFFFF);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [4:0] got_v, exp_v;
    valid_pct = 60;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 20; i++) push_word(d, W'($urandom));
    repeat (450) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL random dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      advance();
    end
    for (int d = 0; d < 3; d++) begin
      chk_cnt++;
      if (o_busy[d] !== 1'b0) $display("FAIL random_drain dut%0d busy got %b expected 0", d, o_busy[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midword();
    logic [4:0] got_v, exp_v;
    int base;
    bit hit;
    valid_pct = 100;
    base = nw[0];
    hit  = 1'b0;
    push_word(0, 8'hAA);
    push_word(0, 8'h55);
    repeat (20) begin
      if (!hit) begin
        for (int d = 0; d < 3; d++) begin
          exp_v = model_out(d, t);
          got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
          chk_cnt++;
          if (got_v !== exp_v) $display("FAIL midreset_pre dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
          else pass_cnt++;
        end
        if (nw[0] > base + 1 && t == ws[0][base] + 3) hit = 1'b1;
        else advance();
      end
    end
    chk_cnt++;
    if (!hit) $display("FAIL midreset_reach got no 4th bit with word held within 20 cycles expected reached");
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
      exp_v = {1'b0, cfg_idle(d), 1'b0, 1'b0, 1'b0};
      chk_cnt++;
      if (got_v !== exp_v) $display("FAIL midreset_async dut%0d got %b expected %b", d, got_v, exp_v);
      else pass_cnt++;
    end
    clear_model();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    repeat (20) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = model_out(d, t);
        got_v = {o_dv[d], o_dout[d], o_sof[d], o_busy[d], o_rdy[d]};
        chk_cnt++;
        if (got_v !== exp_v) $display("FAIL midreset_post dut%0d t=%0d got %b expected %b", d, t, got_v, exp_v);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  initial begin
    clear_model();
    valid_pct = 100;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_lsb_first();
    test_backpressure();
    test_random();
    test_reset_midword();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Upstream stage for the team's Moore sequence detectors: drives their serial `din` input.
- Accepts parallel words over a valid/ready handshake and buffers one word.
- Shifts each word out one bit per clock as a qualified serial stream (`dout`, `dout_valid`, `sof`).
- Optional idle-gap insertion between words keeps detection runs aligned to word boundaries for non-overlapping testing.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- IDLE_BIT, 0: value driven on `dout` whenever `dout_valid` = 0.
- GAP, 0: idle cycles inserted after every word; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  parallel word to serialize.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  holding register empty; transfer occurs when in_valid && in_ready at a clk edge.
- dout  out  1  serial bit; connects to the detector's `din`.
- dout_valid  out  1  `dout` carries a data bit this cycle.
- sof  out  1  high on the first bit of each word.
- busy  out  1  state != S_IDLE or hold_full.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state = S_IDLE, hold_full = 0, bit_cnt = 0, gap_cnt = 0.
  - dout = IDLE_BIT, dout_valid = 0, sof = 0, busy = 0.
  - in_ready = 0 while reset is asserted; in_ready = 1 from the first cycle after deassertion.
- in_ready = !hold_full && !reset.
- All other outputs are decoded from registers only (Moore); no input-to-output combinational path.
- Reset mid-word discards the shifting word and the held word; no partial output after reset.
- Holding register:
  - Loads `in_data` on an accepted transfer.
  - Clears when the shifter takes the word.
  - Accept and take never coincide, because in_ready = 0 whenever hold_full = 1.
- States:
  - S_IDLE:
    - dout_valid = 0.
    - If hold_full: load shift_reg from hold, bit_cnt = 0, hold_full = 0, go to S_SHIFT.
  - S_SHIFT:
    - dout = current bit (shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0]); dout_valid = 1.
    - sof = (bit_cnt == 0).
    - Each edge: shift toward the output end, bit_cnt++.
    - At bit_cnt == WIDTH-1:
      - GAP > 0: go to S_GAP, gap_cnt = GAP-1.
      - else if hold_full: reload directly (back-to-back, no bubble), bit_cnt = 0, stay in S_SHIFT.
      - else: go to S_IDLE.
  - S_GAP:
    - dout = IDLE_BIT, dout_valid = 0.
    - While gap_cnt != 0: decrement.
    - At gap_cnt == 0: reload from hold if hold_full, else go to S_IDLE.
- Latency: transfer accepted at edge k → first bit visible after edge k+1 (1 cycle in hold, then first bit).
- Throughput: with GAP = 0 and the source keeping the hold full, `dout_valid` stays 1 continuously.
- bit_cnt width is $clog2(WIDTH); gap_cnt is 4 bits. Both wrap only via explicit reload, never by overflow.

Decomposition:
- Package serial_src_pkg:
  - State encodings S_IDLE = 2'b00, S_SHIFT = 2'b01, S_GAP = 2'b10.
  - GAP_W = 4.
  - Function next_bit(shift_reg, MSB_FIRST).
- One sub-module, serial_src_hold: the one-word holding register with valid/ready. Keeps the FSM file purely shifter logic.

Test Plan:
- WIDTH=8, MSB_FIRST=1, single word 8'h99 accepted at edge k:
  - from edge k+1: dout = 1,0,0,1,1,0,0,1 on 8 consecutive cycles;
  - sof high only on the first of those cycles;
  - then dout_valid = 0, dout = 0, busy = 0.
- Back-to-back 8'h90 then 8'h09, in_valid held high, GAP=0:
  - 16 contiguous valid bits 1001000000001001, no bubble;
  - sof on bits 0 and 8;
  - in_ready low exactly while a word is held.
- GAP=2, two words 8'hFF, 8'h00:
  - 8 ones, then 2 cycles dout_valid = 0 with dout = IDLE_BIT, then 8 zeros.
- MSB_FIRST=0, word 8'h01:
  - dout = 1 on the sof cycle, then 7 zeros.
- Backpressure, in_valid held high with words A, B, C:
  - A shifting, B held, in_ready = 0;
  - C accepted only on the cycle after B is loaded into the shifter;
  - no word lost or duplicated.
- Reset asserted on the 4th bit of 8'hAA with a word held:
  - dout_valid = 0 and in_ready = 0 immediately (asynchronous);
  - after release, in_ready = 1 and no residual bits are emitted.
